// File: rtl/ad_pixel_capture_if.sv
// ad_pixel_capture_if: groups the ADC-side strobes/bus, the pixel stream and
// the status outputs of ad_pixel_capture into one bundle.
// Ports (signals): ad_adclk/ad_oeb_n/ad_data (ADC side), clear_ovf,
//   pix_data/pix_sol/pix_valid/pix_ready (stream), ovf, line_count,
//   testpat (only with CCD_CAPTURE_TESTPAT_EN defined).
// master = producer of ADC strobes and consumer of pixels; slave = capture block.
interface ad_pixel_capture_if;
    logic        ad_adclk;
    logic        ad_oeb_n;
    logic [7:0]  ad_data;
    logic        clear_ovf;
    logic [15:0] pix_data;
    logic        pix_sol;
    logic        pix_valid;
    logic        pix_ready;
    logic        ovf;
    logic [11:0] line_count;
`ifdef CCD_CAPTURE_TESTPAT_EN
    logic        testpat;

    modport master (
        output ad_adclk, ad_oeb_n, ad_data, clear_ovf, pix_ready, testpat,
        input  pix_data, pix_sol, pix_valid, ovf, line_count
    );
    modport slave (
        input  ad_adclk, ad_oeb_n, ad_data, clear_ovf, pix_ready, testpat,
        output pix_data, pix_sol, pix_valid, ovf, line_count
    );
`else
    modport master (
        output ad_adclk, ad_oeb_n, ad_data, clear_ovf, pix_ready,
        input  pix_data, pix_sol, pix_valid, ovf, line_count
    );
    modport slave (
        input  ad_adclk, ad_oeb_n, ad_data, clear_ovf, pix_ready,
        output pix_data, pix_sol, pix_valid, ovf, line_count
    );
`endif
endinterface

// File: rtl/ad_pixel_capture.sv
// ad_pixel_capture: receive side of the CCD/ADC readout path. Registers the
// multiplexed 8-bit ADC bus, pairs rise/fall bytes into 16-bit pixels, drops
// PIPE_SKIP pixels per line, tags the first kept pixel and queues pixels.
// Ports: clk, rst (sync, active-high), bus (ad_pixel_capture_if.slave).
// Optional feature macro: CCD_CAPTURE_TESTPAT_EN (adds bus.testpat; kept
// pixel data replaced by its index within the line while testpat = 1).

// Generic FIFO with pointer-MSB full/empty detection.
// Latency: push visible at o_vld the cycle after the write; head is combinational.
// Backpressure: push+pop when full both honoured; push when full without pop dropped (o_drop).
module ad_pixel_capture_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_vld,
    output logic         o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_empty;
    logic         w_full;
    logic         w_pop;
    logic         w_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    // When full, the write slot is the slot being popped, so a same-cycle
    // pop frees exactly the entry we overwrite.
    assign w_wr    = i_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

    // Head forced to zero when empty so outputs are defined from reset.
    assign o_dat  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_vld  = ~w_empty;
    assign o_drop = i_push & w_full & ~w_pop;
endmodule

// Pixel capture: strobe registering, line FSM, byte pairing, skip/sol tagging.
// Latency: fall on ADC cycle N -> registered N+1 -> pix_valid N+2 (FIFO empty).
// Backpressure: pix_valid/pix_ready; pixels arriving at a full FIFO are dropped and set ovf.
module ad_pixel_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int PIPE_SKIP  = 3
) (
    input  logic               clk,
    input  logic               rst,
    ad_pixel_capture_if.slave  bus
);
    typedef enum logic {S_IDLE, S_LINE} state_t;

    // Registered ADC strobes and bus (same clock domain as the sequencer).
    logic        r_adclk;
    logic        r_adclk_d;
    logic        r_oeb_n;
    logic [7:0]  r_data;
    logic        w_rise;
    logic        w_fall;

    state_t      r_state, w_state_nxt;
    logic        r_armed, w_armed_nxt;
    logic        r_have_hi, w_have_hi_nxt;
    logic [7:0]  r_hi_byte, w_hi_byte_nxt;
    logic [3:0]  r_skip_cnt, w_skip_cnt_nxt;
    logic        r_sol_pend, w_sol_pend_nxt;
    logic [11:0] r_line_count;
    logic        w_line_inc;
`ifdef CCD_CAPTURE_TESTPAT_EN
    logic [15:0] r_pix_idx, w_pix_idx_nxt;
`endif

    logic        w_push;
    logic [15:0] w_push_dat;
    logic        w_push_sol;
    logic [16:0] w_head;
    logic        w_drop;
    logic        r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adclk   <= 1'b0;
            r_adclk_d <= 1'b0;
            r_oeb_n   <= 1'b0;
            r_data    <= 8'd0;
        end else begin
            r_adclk   <= bus.ad_adclk;
            r_adclk_d <= r_adclk;
            r_oeb_n   <= bus.ad_oeb_n;
            r_data    <= bus.ad_data;
        end
    end

    assign w_rise = r_adclk & ~r_adclk_d;
    assign w_fall = ~r_adclk & r_adclk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_have_hi    <= 1'b0;
            r_hi_byte    <= 8'd0;
            r_skip_cnt   <= 4'd0;
            r_sol_pend   <= 1'b0;
            r_line_count <= 12'd0;
`ifdef CCD_CAPTURE_TESTPAT_EN
            r_pix_idx    <= 16'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_armed    <= w_armed_nxt;
            r_have_hi  <= w_have_hi_nxt;
            r_hi_byte  <= w_hi_byte_nxt;
            r_skip_cnt <= w_skip_cnt_nxt;
            r_sol_pend <= w_sol_pend_nxt;
            if (w_line_inc) r_line_count <= r_line_count + 12'd1;
`ifdef CCD_CAPTURE_TESTPAT_EN
            r_pix_idx  <= w_pix_idx_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_armed_nxt    = r_armed;
        w_have_hi_nxt  = r_have_hi;
        w_hi_byte_nxt  = r_hi_byte;
        w_skip_cnt_nxt = r_skip_cnt;
        w_sol_pend_nxt = r_sol_pend;
        w_line_inc     = 1'b0;
        w_push         = 1'b0;
        w_push_sol     = r_sol_pend;
        w_push_dat     = {r_hi_byte, r_data};
`ifdef CCD_CAPTURE_TESTPAT_EN
        w_pix_idx_nxt  = r_pix_idx;
        if (bus.testpat) w_push_dat = r_pix_idx;
`endif
        case (r_state)
            S_IDLE: begin
                // Registered oeb resets low, so a line may only start once
                // oeb has been seen high; this keeps a mid-line reset from
                // capturing the tail of the interrupted line.
                if (r_oeb_n) begin
                    w_armed_nxt = 1'b1;
                end else if (r_armed) begin
                    w_state_nxt    = S_LINE;
                    w_armed_nxt    = 1'b0;
                    w_have_hi_nxt  = 1'b0;
                    w_skip_cnt_nxt = 4'(PIPE_SKIP);
                    w_sol_pend_nxt = 1'b1;
`ifdef CCD_CAPTURE_TESTPAT_EN
                    w_pix_idx_nxt  = 16'd0;
`endif
                end
            end
            S_LINE: begin
                // Line end wins over any edge registered in the same cycle.
                if (r_oeb_n) begin
                    w_state_nxt   = S_IDLE;
                    w_line_inc    = 1'b1;
                    w_have_hi_nxt = 1'b0;
                end else if (w_rise) begin
                    w_hi_byte_nxt = r_data;
                    w_have_hi_nxt = 1'b1;
                end else if (w_fall && r_have_hi) begin
                    w_have_hi_nxt = 1'b0;
                    if (r_skip_cnt != 4'd0) begin
                        w_skip_cnt_nxt = r_skip_cnt - 4'd1;
                    end else begin
                        w_push         = 1'b1;
                        w_sol_pend_nxt = 1'b0;
`ifdef CCD_CAPTURE_TESTPAT_EN
                        w_pix_idx_nxt  = r_pix_idx + 16'd1;
`endif
                    end
                end
            end
        endcase
    end

    ad_pixel_capture_fifo #(
        .W     (17),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat ({w_push_sol, w_push_dat}),
        .i_pop      (bus.pix_ready),
        .o_dat      (w_head),
        .o_vld      (bus.pix_valid),
        .o_drop     (w_drop)
    );

    // A new drop beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)                r_ovf <= 1'b0;
        else if (w_drop)        r_ovf <= 1'b1;
        else if (bus.clear_ovf) r_ovf <= 1'b0;
    end

    assign bus.pix_data   = w_head[15:0];
    assign bus.pix_sol    = w_head[16];
    assign bus.ovf        = r_ovf;
    assign bus.line_count = r_line_count;
endmodule

// File: tb/tb_ad_pixel_capture.sv
module tb_ad_pixel_capture;
    localparam int SKIP  = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ad_pixel_capture_if bus();

    ad_pixel_capture #(.FIFO_DEPTH(DEPTH), .PIPE_SKIP(SKIP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        sol;
    } pix_t;

    typedef struct {
        int         npix;
        int         gap;
        int         exp_kept;
        logic [7:0] seed;
    } vec_t;

    pix_t       exp_q[$];
    logic [7:0] lhi [16];
    logic [7:0] llo [16];
    int         errors = 0;
    int         checks = 0;
    int         popped = 0;
    int         exp_lines = 0;
    int         ready_mode = 0;   // 0: hold off, 1: always ready, 2: random
    int         low_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Consumer: drives pix_ready and scores every accepted pixel.
    initial begin : consumer
        pix_t e;
        bus.pix_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1: bus.pix_ready = 1'b1;
                2: begin
                    if (low_run >= 3) bus.pix_ready = 1'b1;
                    else              bus.pix_ready = 1'($urandom_range(0, 1));
                    low_run = bus.pix_ready ? 0 : low_run + 1;
                end
                default: bus.pix_ready = 1'b0;
            endcase
            if (!rst && bus.pix_valid && bus.pix_ready) begin
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected actual=0x%0h sol=%0b expected=none",
                             bus.pix_data, bus.pix_sol);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.pix_data !== e.data || bus.pix_sol !== e.sol) begin
                        errors++;
                        $display("FAIL pop_data actual=0x%0h/sol%0b expected=0x%0h/sol%0b",
                                 bus.pix_data, bus.pix_sol, e.data, e.sol);
                    end
                end
            end
        end
    end

    // Reference: of npix pixels the first SKIP are lost, the next is tagged,
    // and at most 'limit' of the kept ones reach the FIFO.
    task automatic model_line(input int npix, input bit tp, input int limit, output int nkept);
        pix_t e;
        nkept = 0;
        for (int k = SKIP; k < npix; k++) begin
            e.data = tp ? 16'(k - SKIP) : {lhi[k], llo[k]};
            e.sol  = (k == SKIP);
            if (nkept < limit) exp_q.push_back(e);
            nkept++;
        end
    endtask

    task automatic fill_pattern(input logic [7:0] seed);
        for (int k = 0; k < 16; k++) begin
            lhi[k] = seed + 8'(8'h44 * k);
            llo[k] = seed + 8'h22 + 8'(8'h44 * k);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 16; k++) begin
            lhi[k] = 8'($urandom);
            llo[k] = 8'($urandom);
        end
    endtask

    // One readout line: oeb falls with adclk high, a leading fall, then
    // rise(hi)/fall(lo) per pixel. end_on_fall raises oeb with the last fall.
    task automatic run_line(input int npix, input int gap, input bit end_on_fall, input bit probe_ovf);
        bus.ad_oeb_n = 1'b0;
        wait_cyc(gap);
        bus.ad_adclk = 1'b0;
        wait_cyc(gap);
        for (int k = 0; k < npix; k++) begin
            bus.ad_data  = lhi[k];
            bus.ad_adclk = 1'b1;
            wait_cyc(gap);
            bus.ad_data  = llo[k];
            if (end_on_fall && k == npix - 1) bus.ad_oeb_n = 1'b1;
            bus.ad_adclk = 1'b0;
            wait_cyc(gap);
            if (probe_ovf && k >= SKIP)
                chk("ovf_progress", {31'd0, bus.ovf}, {31'd0, (k - SKIP + 1) >= 5});
        end
        bus.ad_oeb_n = 1'b1;
        wait_cyc(gap);
        bus.ad_adclk = 1'b1;
        wait_cyc(gap);
        exp_lines++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.pix_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        wait_cyc(3);
    endtask

    vec_t vecs[5];

    initial begin : main
        int nk;
        int total;
        vecs[0] = '{npix: 6, gap: 2, exp_kept: 3, seed: 8'h12};
        vecs[1] = '{npix: 3, gap: 3, exp_kept: 0, seed: 8'h01};
        vecs[2] = '{npix: 4, gap: 2, exp_kept: 1, seed: 8'hA0};
        vecs[3] = '{npix: 0, gap: 4, exp_kept: 0, seed: 8'h33};
        vecs[4] = '{npix: 8, gap: 3, exp_kept: 5, seed: 8'h5C};

        bus.ad_adclk  = 1'b1;
        bus.ad_oeb_n  = 1'b1;
        bus.ad_data   = 8'd0;
        bus.clear_ovf = 1'b0;
`ifdef CCD_CAPTURE_TESTPAT_EN
        bus.testpat   = 1'b0;
`endif
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(1);
        chk("rst_pix_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("rst_pix_sol", {31'd0, bus.pix_sol}, 32'd0);
        chk("rst_pix_data", {16'd0, bus.pix_data}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rst_line_count", {20'd0, bus.line_count}, 32'd0);
        wait_cyc(3);

        // Table-driven lines, consumer always ready.
        ready_mode = 1;
        for (int i = 0; i < 5; i++) begin
            popped = 0;
            fill_pattern(vecs[i].seed);
            model_line(vecs[i].npix, 1'b0, 99, nk);
            run_line(vecs[i].npix, vecs[i].gap, 1'b0, 1'b0);
            wait_drain();
            chk("vec_kept_count", 32'(popped), 32'(vecs[i].exp_kept));
            chk("vec_line_count", {20'd0, bus.line_count}, 32'(exp_lines % 4096));
        end

        // Backpressure and overflow: 10 kept pixels into a 4-deep FIFO.
        ready_mode = 0;
        wait_cyc(2);
        popped = 0;
        fill_pattern(8'h21);
        model_line(13, 1'b0, DEPTH, nk);
        run_line(13, 2, 1'b0, 1'b1);
        chk("bp_valid", {31'd0, bus.pix_valid}, 32'd1);
        chk("bp_head_data", {16'd0, bus.pix_data}, {16'd0, lhi[SKIP], llo[SKIP]});
        chk("bp_head_sol", {31'd0, bus.pix_sol}, 32'd1);
        wait_cyc(6);
        chk("bp_head_held", {16'd0, bus.pix_data}, {16'd0, lhi[SKIP], llo[SKIP]});
        ready_mode = 1;
        wait_drain();
        chk("bp_drain_count", 32'(popped), 32'(DEPTH));
        chk("bp_ovf_sticky", {31'd0, bus.ovf}, 32'd1);
        bus.clear_ovf = 1'b1;
        wait_cyc(1);
        bus.clear_ovf = 1'b0;
        wait_cyc(1);
        chk("ovf_cleared", {31'd0, bus.ovf}, 32'd0);

        // Line end coincident with the last pixel's fall: that pixel is lost.
        popped = 0;
        fill_pattern(8'h77);
        model_line(4, 1'b0, 99, nk);
        run_line(5, 3, 1'b1, 1'b0);
        wait_drain();
        chk("edge_end_count", 32'(popped), 32'd1);
        chk("edge_end_lines", {20'd0, bus.line_count}, 32'(exp_lines % 4096));

        // Randomised lines with random (bounded) backpressure.
        ready_mode = 2;
        popped = 0;
        total = 0;
        for (int i = 0; i < 20; i++) begin
            fill_random();
            model_line(int'($urandom_range(0, 9)), 1'b0, 99, nk);
            total += nk;
            run_line(nk == 0 ? int'($urandom_range(0, SKIP)) : nk + SKIP,
                     int'($urandom_range(3, 5)), 1'b0, 1'b0);
        end
        wait_drain();
        chk("rand_count", 32'(popped), 32'(total));
        chk("rand_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("rand_lines", {20'd0, bus.line_count}, 32'(exp_lines % 4096));

`ifdef CCD_CAPTURE_TESTPAT_EN
        // Test pattern: data replaced by index within the line.
        ready_mode = 1;
        bus.testpat = 1'b1;
        for (int k = 0; k < 16; k++) begin
            lhi[k] = 8'hFF;
            llo[k] = 8'hFF;
        end
        for (int i = 0; i < 2; i++) begin
            popped = 0;
            model_line(6, 1'b1, 99, nk);
            run_line(6, 2, 1'b0, 1'b0);
            wait_drain();
            chk("tp_count", 32'(popped), 32'd3);
        end
        bus.testpat = 1'b0;
`endif

        // Reset in the middle of a line after 2 kept pixels.
        ready_mode = 0;
        wait_cyc(2);
        fill_pattern(8'h40);
        bus.ad_oeb_n = 1'b0;
        wait_cyc(2);
        bus.ad_adclk = 1'b0;
        wait_cyc(2);
        for (int k = 0; k < SKIP + 2; k++) begin
            bus.ad_data = lhi[k]; bus.ad_adclk = 1'b1; wait_cyc(2);
            bus.ad_data = llo[k]; bus.ad_adclk = 1'b0; wait_cyc(2);
        end
        chk("mid_prereset_valid", {31'd0, bus.pix_valid}, 32'd1);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        exp_q.delete();
        exp_lines = 0;
        wait_cyc(1);
        chk("mid_rst_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("mid_rst_lines", {20'd0, bus.line_count}, 32'd0);
        // Remaining pixels of the interrupted line must be ignored.
        for (int k = 0; k < 4; k++) begin
            bus.ad_data = lhi[k]; bus.ad_adclk = 1'b1; wait_cyc(2);
            bus.ad_data = llo[k]; bus.ad_adclk = 1'b0; wait_cyc(2);
        end
        bus.ad_oeb_n = 1'b1;
        wait_cyc(3);
        bus.ad_adclk = 1'b1;
        wait_cyc(3);
        chk("mid_tail_ignored", {31'd0, bus.pix_valid}, 32'd0);
        chk("mid_tail_lines", {20'd0, bus.line_count}, 32'd0);
        ready_mode = 1;
        popped = 0;
        fill_pattern(8'h12);
        model_line(6, 1'b0, 99, nk);
        run_line(6, 2, 1'b0, 1'b0);
        wait_drain();
        chk("post_rst_count", 32'(popped), 32'd3);
        chk("post_rst_lines", {20'd0, bus.line_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
